// File: rtl/memory_pkg.sv
// Shared constants and types for the frame memory arbiter.
// Frame geometry, bus widths, owner tags and arbiter FSM states.
// No logic here; imported by every frame_mem_arbiter file.
package memory_pkg;

    localparam int FRAME_W      = 320;
    localparam int FRAME_H      = 240;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;   // 76800
    localparam int ADDR_W       = 17;
    localparam int DATA_W       = 8;
    localparam int RD_LAT_DEF   = 2;
    localparam int MAX_WAIT     = 4;
    localparam int WAIT_W       = $clog2(MAX_WAIT + 1);

    // Who issued the read travelling down the tag pipe
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_ALG  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/frame_mem_arbiter_if.sv
// Requester and RAM-port bundle for the frame memory arbiter.
// Pure wiring, no latency.
// Requesters hold req/addr/we/wdata until they see gnt.
interface frame_mem_arbiter_if;
    import memory_pkg::*;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;

    logic              alg_req;
    logic              alg_we;
    logic [ADDR_W-1:0] alg_addr;
    logic [DATA_W-1:0] alg_wdata;
    logic              alg_gnt;
    logic              alg_rvalid;
    logic [DATA_W-1:0] alg_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  vga_req, vga_addr, alg_req, alg_we, alg_addr, alg_wdata, mem_rdata,
        output vga_gnt, vga_rvalid, vga_rdata, alg_gnt, alg_rvalid, alg_rdata,
        output mem_addr, mem_wdata, mem_we, busy
    );

    // Requester / RAM side
    modport master (
        output vga_req, vga_addr, alg_req, alg_we, alg_addr, alg_wdata, mem_rdata,
        input  vga_gnt, vga_rvalid, vga_rdata, alg_gnt, alg_rvalid, alg_rdata,
        input  mem_addr, mem_wdata, mem_we, busy
    );

endinterface

// File: rtl/frame_mem_arbiter_rd_tag_pipe.sv
// Owner-tag shift register, RD_LAT+1 stages, last stage aligned with mem_rdata.
// Latency: tag_in captured with the grant, appears on tag_out RD_LAT+1 cycles later.
// No backpressure: the RAM never stalls, so the pipe shifts whenever enabled.
module rd_tag_pipe
    import memory_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   en,
    input  owner_t tag_in,
    output owner_t tag_out,
    output logic   busy,
    output logic   pending
);

    owner_t stage [RD_LAT+1];

    // Shift tags one stage per cycle; reset discards all in-flight reads
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= RD_LAT; i++) stage[i] <= OWN_NONE;
        end else if (en) begin
            stage[0] <= tag_in;
            for (int i = 1; i <= RD_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    // busy: anything in flight; pending: something still in flight after this cycle's shift
    always_comb begin
        busy    = 1'b0;
        pending = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) begin
            if (stage[i] != OWN_NONE) begin
                busy = 1'b1;
                if (i < RD_LAT) pending = 1'b1;
            end
        end
    end

    assign tag_out = stage[RD_LAT];

endmodule

// File: rtl/frame_mem_arbiter.sv
// Single-port frame RAM arbiter: VGA reader vs zoom engine, one grant per cycle.
// Latency: grant in N -> RAM port in N+1 -> read data to owner in N+2+RD_LAT.
// Backpressure: combinational gnt; losers hold req. Optional FRAME_MEM_STARVE_GUARD_EN.
module frame_mem_arbiter
    import memory_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    frame_mem_arbiter_if.slave  bus
);

    logic              alg_first;
    logic              vga_gnt_c;
    logic              alg_gnt_c;
    logic              any_gnt;
    owner_t            tag_in;
    owner_t            tag_out;
    logic              pipe_busy;
    logic              pipe_pending;
    arb_state_t        state;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              vga_rvalid_q;
    logic [DATA_W-1:0] vga_rdata_q;
    logic              alg_rvalid_q;
    logic [DATA_W-1:0] alg_rdata_q;

`ifdef FRAME_MEM_STARVE_GUARD_EN
    logic [WAIT_W-1:0] wait_cnt;

    // Count consecutive denied algorithm cycles, saturating at MAX_WAIT
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!bus.alg_req || alg_gnt_c) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign alg_first = (wait_cnt == WAIT_W'(MAX_WAIT));
`else
    assign alg_first = 1'b0;
`endif

    // VGA wins contention unless the algorithm has been starved long enough;
    // nothing is granted while reset is held so no request is silently lost
    always_comb begin
        vga_gnt_c = 1'b0;
        alg_gnt_c = 1'b0;
        if (reset_n) begin
            if (bus.vga_req && !(bus.alg_req && alg_first)) vga_gnt_c = 1'b1;
            else if (bus.alg_req)                            alg_gnt_c = 1'b1;
        end
    end

    assign any_gnt = vga_gnt_c | alg_gnt_c;

    // Only reads occupy a tag slot; writes produce no return
    always_comb begin
        tag_in = OWN_NONE;
        if (vga_gnt_c)                    tag_in = OWN_VGA;
        else if (alg_gnt_c && !bus.alg_we) tag_in = OWN_ALG;
    end

    // In IDLE the pipe is known empty, so it only needs to move once a grant arrives
    rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (any_gnt || (state != ST_IDLE)),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .busy    (pipe_busy),
        .pending (pipe_pending)
    );

    // Arbiter FSM with the registered RAM port as its outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (vga_gnt_c) begin
                mem_addr_q <= bus.vga_addr;
            end else if (alg_gnt_c) begin
                mem_addr_q <= bus.alg_addr;
                if (bus.alg_we) begin
                    mem_wdata_q <= bus.alg_wdata;
                    mem_we_q    <= 1'b1;
                end
            end

            unique case (state)
                ST_IDLE: begin
                    if (any_gnt) state <= ST_SERVE;
                end
                ST_SERVE, ST_DRAIN: begin
                    if (any_gnt)           state <= ST_SERVE;
                    else if (pipe_pending) state <= ST_DRAIN;
                    else                   state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Route the pixel leaving the RAM to whoever issued the read
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vga_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
            alg_rvalid_q <= 1'b0;
            alg_rdata_q  <= '0;
        end else begin
            vga_rvalid_q <= (tag_out == OWN_VGA);
            alg_rvalid_q <= (tag_out == OWN_ALG);
            if (tag_out == OWN_VGA) vga_rdata_q <= bus.mem_rdata;
            if (tag_out == OWN_ALG) alg_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.vga_gnt    = vga_gnt_c;
    assign bus.alg_gnt    = alg_gnt_c;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.vga_rvalid = vga_rvalid_q;
    assign bus.vga_rdata  = vga_rdata_q;
    assign bus.alg_rvalid = alg_rvalid_q;
    assign bus.alg_rdata  = alg_rdata_q;
    assign bus.busy       = pipe_busy;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: RAM model with 2-cycle read latency plus a
// transaction-level reference (grant rule, shadow memory, timed return queue).
module tb_frame_mem_arbiter;
    import memory_pkg::*;

    localparam int LAT = RD_LAT_DEF + 2;   // grant cycle -> rvalid cycle

    logic clock;
    logic reset_n;

    frame_mem_arbiter_if bus();

    frame_mem_arbiter #(.RD_LAT(RD_LAT_DEF)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment RAM: address registered by the DUT, data RD_LAT cycles later
    logic [7:0] ram     [0:131071];
    logic [7:0] ref_mem [0:131071];
    logic [7:0] rd_s1;

    always @(posedge clock) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rd_s1         <= ram[bus.mem_addr];
        bus.mem_rdata <= rd_s1;
    end

    typedef struct {
        logic       own_vga;
        logic [7:0] data;
        int         due;
    } ret_t;

    ret_t        q[$];
    int          cyc;
    int          n_vec;
    int          n_err;
    int          n_exp_ret;
    int          n_obs_ret;
    int          streak;
    logic        last_gv;
    logic        last_ga;
    logic [7:0]  last_vga;
    logic [7:0]  last_alg;
    logic [16:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        streak    = 0;
        last_vga  = 8'h00;
        last_alg  = 8'h00;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_we    = 1'b0;
        last_gv   = 1'b0;
        last_ga   = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vga_gnt"},    bus.vga_gnt,    0);
        chk({tag, "_alg_gnt"},    bus.alg_gnt,    0);
        chk({tag, "_vga_rvalid"}, bus.vga_rvalid, 0);
        chk({tag, "_alg_rvalid"}, bus.alg_rvalid, 0);
        chk({tag, "_vga_rdata"},  bus.vga_rdata,  0);
        chk({tag, "_alg_rdata"},  bus.alg_rdata,  0);
        chk({tag, "_mem_addr"},   bus.mem_addr,   0);
        chk({tag, "_mem_wdata"},  bus.mem_wdata,  0);
        chk({tag, "_mem_we"},     bus.mem_we,     0);
        chk({tag, "_busy"},       bus.busy,       0);
    endtask

    // One clock cycle: check outputs mid-cycle against the reference, then advance it
    task automatic cycle();
        logic ev, ea, wins, exp_vr, exp_ar, exp_busy;
        ret_t r;
        @(negedge clock);
        wins = 1'b0;
`ifdef FRAME_MEM_STARVE_GUARD_EN
        wins = (streak >= MAX_WAIT);
`endif
        ev = bus.vga_req && !(bus.alg_req && wins);
        ea = bus.alg_req && !ev;
        chk("vga_gnt", bus.vga_gnt, ev);
        chk("alg_gnt", bus.alg_gnt, ea);

        exp_vr = 1'b0;
        exp_ar = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            if (r.own_vga) begin exp_vr = 1'b1; last_vga = r.data; end
            else           begin exp_ar = 1'b1; last_alg = r.data; end
        end
        chk("vga_rvalid", bus.vga_rvalid, exp_vr);
        chk("alg_rvalid", bus.alg_rvalid, exp_ar);
        chk("vga_rdata",  bus.vga_rdata,  last_vga);
        chk("alg_rdata",  bus.alg_rdata,  last_alg);
        if (bus.vga_rvalid || bus.alg_rvalid) n_obs_ret++;

        exp_busy = 1'b0;
        foreach (q[i]) if (q[i].due <= cyc + LAT - 1) exp_busy = 1'b1;
        chk("busy", bus.busy, exp_busy);

        chk("mem_we",   bus.mem_we,   exp_we);
        chk("mem_addr", bus.mem_addr, exp_addr);
        if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);

        exp_we = 1'b0;
        if (ev) begin
            q.push_back('{own_vga: 1'b1, data: ref_mem[bus.vga_addr], due: cyc + LAT});
            n_exp_ret++;
            exp_addr = bus.vga_addr;
        end else if (ea) begin
            exp_addr = bus.alg_addr;
            if (bus.alg_we) begin
                ref_mem[bus.alg_addr] = bus.alg_wdata;
                exp_wdata = bus.alg_wdata;
                exp_we    = 1'b1;
            end else begin
                q.push_back('{own_vga: 1'b0, data: ref_mem[bus.alg_addr], due: cyc + LAT});
                n_exp_ret++;
            end
        end
        if (bus.alg_req && !ea) streak++;
        else                    streak = 0;
        last_gv = ev;
        last_ga = ea;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic logic [16:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return 17'h1FFFF - 17'($urandom_range(0, 3));
        return 17'($urandom_range(0, 63));
    endfunction

    initial begin
        int first_alg;
        int n_alg_g;
        int ret_base;
        logic [16:0] a;

        n_vec = 0; n_err = 0; n_exp_ret = 0; n_obs_ret = 0; cyc = 0;
        for (int i = 0; i < 131072; i++) begin
            a = 17'(i);
            ram[i]     = a[7:0] ^ {a[15:9], a[16]} ^ 8'h5A;
            ref_mem[i] = ram[i];
        end
        ram[100] = 8'hA5; ref_mem[100] = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            ram[200 + i] = 8'h10 + 8'(i); ref_mem[200 + i] = 8'h10 + 8'(i);
        end
        model_reset();

        // Reset state
        reset_n = 1'b0;
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        bus.alg_req = 1'b0; bus.alg_we = 1'b0; bus.alg_addr = '0; bus.alg_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;

        // VGA alone reads address 100 in cycle 10
        while (cyc < 10) cycle();
        bus.vga_req = 1'b1; bus.vga_addr = 17'd100;
        ret_base = n_obs_ret;
        cycle();
        bus.vga_req = 1'b0;
        repeat (5) cycle();
        chk("vga_single_returns", n_obs_ret - ret_base, 1);
        chk("vga_single_data", bus.vga_rdata, 8'hA5);

        // Algorithm write then read-back of the same pixel
        bus.alg_req = 1'b1; bus.alg_we = 1'b1; bus.alg_addr = 17'd19200; bus.alg_wdata = 8'h3C;
        cycle();
        bus.alg_req = 1'b0; bus.alg_we = 1'b0;
        cycle();
        cycle();
        bus.alg_req = 1'b1; bus.alg_addr = 17'd19200;
        cycle();
        bus.alg_req = 1'b0;
        repeat (5) cycle();
        chk("alg_readback", bus.alg_rdata, 8'h3C);

        // Simultaneous requests: VGA first, algorithm next cycle
        bus.vga_req = 1'b1; bus.vga_addr = 17'd600;
        bus.alg_req = 1'b1; bus.alg_addr = 17'd601;
        cycle();
        if (last_gv) bus.vga_req = 1'b0;
        cycle();
        if (last_ga) bus.alg_req = 1'b0;
        bus.vga_req = 1'b0; bus.alg_req = 1'b0;
        repeat (6) cycle();

        // Interleaved reads every cycle for 8 cycles
        ret_base = n_obs_ret;
        for (int i = 0; i < 8; i++) begin
            bus.vga_req = (i % 2 == 0); bus.vga_addr = 17'(200 + i);
            bus.alg_req = (i % 2 == 1); bus.alg_addr = 17'(200 + i); bus.alg_we = 1'b0;
            cycle();
        end
        bus.vga_req = 1'b0; bus.alg_req = 1'b0;
        repeat (6) cycle();
        chk("interleave_returns", n_obs_ret - ret_base, 8);

        // Both requesters held continuously
        bus.vga_req = 1'b1; bus.vga_addr = 17'd400;
        bus.alg_req = 1'b1; bus.alg_we = 1'b0; bus.alg_addr = 17'd500;
        first_alg = 0; n_alg_g = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (last_ga) begin
                n_alg_g++;
                if (first_alg == 0) first_alg = i;
                bus.alg_addr = bus.alg_addr + 17'd1;
            end
            if (last_gv) bus.vga_addr = bus.vga_addr + 17'd1;
        end
`ifdef FRAME_MEM_STARVE_GUARD_EN
        chk("starve_first_alg", first_alg, MAX_WAIT + 1);
`else
        chk("starve_alg_grants", n_alg_g, 0);
`endif
        bus.vga_req = 1'b0; bus.alg_req = 1'b0;
        repeat (6) cycle();

        // Reset one cycle after two reads are granted
        bus.vga_req = 1'b1; bus.vga_addr = 17'd100;
        cycle();
        bus.vga_req = 1'b0;
        bus.alg_req = 1'b1; bus.alg_addr = 17'd19200;
        cycle();
        bus.alg_req = 1'b0;
        cycle();
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        ret_base = n_obs_ret;
        n_exp_ret = n_obs_ret;
        repeat (6) cycle();
        chk("midreset_no_rvalid", n_obs_ret - ret_base, 0);
        bus.vga_req = 1'b1; bus.vga_addr = 17'd100;
        cycle();
        bus.vga_req = 1'b0;
        repeat (5) cycle();
        chk("post_reset_read", bus.vga_rdata, 8'hA5);

        // Randomized traffic, including hazards and out-of-frame addresses
        for (int i = 0; i < 400; i++) begin
            if (!bus.vga_req || last_gv || $urandom_range(0, 7) == 0) begin
                bus.vga_req  = ($urandom_range(0, 2) == 0);
                bus.vga_addr = rnd_addr();
            end
            if (!bus.alg_req || last_ga || $urandom_range(0, 7) == 0) begin
                bus.alg_req   = ($urandom_range(0, 1) == 1);
                bus.alg_we    = ($urandom_range(0, 1) == 1);
                bus.alg_addr  = rnd_addr();
                bus.alg_wdata = 8'($urandom_range(0, 255));
            end
            cycle();
        end
        bus.vga_req = 1'b0; bus.alg_req = 1'b0;
        repeat (8) cycle();
        chk("total_returns", n_obs_ret, n_exp_ret);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
